// File: rtl/prog_ram_pkg.sv
// rtl/prog_ram_pkg.sv - shared types and helpers for the program/data RAM
package prog_ram_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_PROG  = 2'd2,
        ST_PDONE = 2'd3
    } state_e;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/prog_ram_if.sv
// rtl/prog_ram_if.sv - program-loader handshake between front panel/UART and the RAM
interface prog_ram_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              prog_mode;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;
    logic [ADDR_W-1:0] prog_addr;
    logic              prog_done;

    modport master (
        output prog_mode, prog_valid, prog_data,
        input  prog_ready, prog_addr, prog_done
    );

    modport slave (
        input  prog_mode, prog_valid, prog_data,
        output prog_ready, prog_addr, prog_done
    );
endinterface

// File: rtl/prog_ram_ram_core.sv
// rtl/prog_ram_ram_core.sv - storage array, one synchronous write port, one asynchronous read port
module ram_core
    import prog_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - CPU main-bus RAM with clear-on-reset and a valid/ready program loader
module prog_ram
    import prog_ram_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] mem_out,
    output logic              busy,
    prog_ram_if.slave         prog
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(depth_of(ADDR_W) - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0] prog_ptr_q, prog_ptr_d;
    logic              prog_done_q, prog_done_d;

    logic              we_c;
    logic [ADDR_W-1:0] waddr_c;
    logic [DATA_W-1:0] wdata_c;
    logic              bus_oe_c;
    logic              ready_c;
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_ptr_q   <= '0;
            prog_ptr_q  <= '0;
            prog_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            prog_ptr_q  <= prog_ptr_d;
            prog_done_q <= prog_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        prog_ptr_d  = prog_ptr_q;
        prog_done_d = prog_done_q;
        we_c        = 1'b0;
        waddr_c     = addr;
        wdata_c     = bus;
        bus_oe_c    = 1'b0;
        ready_c     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                we_c      = 1'b1;
                waddr_c   = clr_ptr_q;
                wdata_c   = '0;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Read wins a collision so the RAM never latches its own output.
                bus_oe_c = rd_en;
                we_c     = wr_en & ~rd_en;
                if (prog.prog_mode) begin
                    state_d     = ST_PROG;
                    prog_ptr_d  = '0;
                    prog_done_d = 1'b0;
                end
            end
            ST_PROG: begin
                ready_c = 1'b1;
                if (!prog.prog_mode) begin
                    state_d = ST_RUN;
                end else if (prog.prog_valid) begin
                    we_c       = 1'b1;
                    waddr_c    = prog_ptr_q;
                    wdata_c    = prog.prog_data;
                    prog_ptr_d = prog_ptr_q + ADDR_W'(1);
                    if (prog_ptr_q == LAST) begin
                        prog_done_d = 1'b1;
                        state_d     = ST_PDONE;
                    end
                end
            end
            ST_PDONE: begin
                if (!prog.prog_mode) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A reset edge must not commit a half-finished load or bus write.
    ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (we_c & rst_n),
        .waddr (waddr_c),
        .wdata (wdata_c),
        .raddr (addr),
        .rdata (rdata)
    );

    assign bus             = bus_oe_c ? rdata : {DATA_W{1'bz}};
    assign mem_out         = (state_q == ST_CLEAR) ? '0 : rdata;
    assign busy            = (state_q == ST_CLEAR);
    assign prog.prog_ready = ready_c;
    assign prog.prog_addr  = prog_ptr_q;
    assign prog.prog_done  = prog_done_q;

endmodule

// File: tb/tb_prog_ram.sv
// tb/tb_prog_ram.sv - scoreboard bench for prog_ram
module tb_prog_ram;
    localparam int SEL_BUS   = 0;
    localparam int SEL_MEM   = 1;
    localparam int SEL_BUSY  = 2;
    localparam int SEL_READY = 3;
    localparam int SEL_PADDR = 4;
    localparam int SEL_DONE  = 5;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en;
    logic [3:0] addr;
    wire  [7:0] bus;
    logic [7:0] mem_out;
    logic       busy;
    logic       tb_oe;
    logic [7:0] tb_bus;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   failed = 0;

    prog_ram_if #(.DATA_W(8), .ADDR_W(4)) pif ();

    assign bus = tb_oe ? tb_bus : 8'hzz;

    prog_ram #(.DATA_W(8), .ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (addr),
        .bus     (bus),
        .mem_out (mem_out),
        .busy    (busy),
        .prog    (pif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // Bus high-Z is observed by driving 0x00 from the bench: any DUT drive corrupts it.
    task automatic expect_bus_z(input string name);
        tb_oe  = 1'b1;
        tb_bus = 8'h00;
        expect_val(name, SEL_BUS, 8'h00);
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        addr = a; tb_oe = 1'b1; tb_bus = d; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        for (int i = 0; i < 16; i++) begin
            addr = 4'd15; rd_en = 1'b1; wr_en = 1'b1;
            expect_val({tag, "_busy_hi"}, SEL_BUSY, 8'h01);
            expect_val({tag, "_memout_clr"}, SEL_MEM, 8'h00);
            expect_bus_z({tag, "_bus_z_clr"});
            step();
        end
        rd_en = 1'b0; wr_en = 1'b0;
        expect_val({tag, "_busy_lo"}, SEL_BUSY, 8'h00);
        expect_val({tag, "_done_lo"}, SEL_DONE, 8'h00);
        step();
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            expect_val({tag, "_zero"}, SEL_MEM, 8'h00);
            expect_bus_z({tag, "_bus_z"});
            step();
        end
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.sel)
                    SEL_BUS:   act = bus;
                    SEL_MEM:   act = mem_out;
                    SEL_BUSY:  act = {7'd0, busy};
                    SEL_READY: act = {7'd0, pif.prog_ready};
                    SEL_PADDR: act = {4'd0, pif.prog_addr};
                    default:   act = {7'd0, pif.prog_done};
                endcase
                tests_run++;
                if (act !== e.exp) begin
                    failed++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin : stimulus
        int idx;
        int cyc;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0;
        tb_oe = 1'b0; tb_bus = '0;
        pif.prog_mode = 1'b0; pif.prog_valid = 1'b0; pif.prog_data = '0;
        step();
        rst_n = 1'b1;
        expect_val("reset_ready", SEL_READY, 8'h00);
        expect_val("reset_done", SEL_DONE, 8'h00);
        repeat (16) step();

        // Test 1: garbage, then a one-cycle reset pulse clears everything
        for (int a = 0; a < 16; a++) write_word(4'(a), 8'hC0 | 8'(a));
        tb_oe = 1'b0; addr = 4'd3;
        expect_val("garbage_present", SEL_MEM, 8'hC3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_clear("t1");

        // Test 2: write then zero-latency read
        write_word(4'd3, 8'hA5);
        tb_oe = 1'b0; rd_en = 1'b1; addr = 4'd3;
        expect_val("t2_read", SEL_BUS, 8'hA5);
        step();
        rd_en = 1'b0;
        expect_bus_z("t2_bus_z");
        step();

        // Test 3: read/write collision, read wins
        write_word(4'd5, 8'h11);
        tb_oe = 1'b0; rd_en = 1'b1; wr_en = 1'b1; addr = 4'd5;
        expect_val("t3_collide_bus", SEL_BUS, 8'h11);
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        expect_val("t3_mem_kept", SEL_MEM, 8'h11);
        step();

        // Test 4: full 16-word load with two valid-low gaps
        pif.prog_mode = 1'b1;
        step();
        idx = 0; cyc = 0;
        while (idx < 16 && cyc < 40) begin
            pif.prog_valid = !(cyc == 3 || cyc == 8);
            pif.prog_data  = 8'h10 + 8'(idx);
            rd_en = 1'b1; addr = 4'd0;
            expect_val("t4_ready", SEL_READY, 8'h01);
            expect_val("t4_paddr", SEL_PADDR, 8'(idx));
            expect_val("t4_done_lo", SEL_DONE, 8'h00);
            expect_bus_z("t4_bus_z");
            step();
            if (pif.prog_valid) idx++;
            cyc++;
        end
        expect_val("t4_cycles", SEL_PADDR, 8'(cyc == 18 ? 0 : 8'hFF));
        pif.prog_valid = 1'b0; rd_en = 1'b0; addr = 4'd7;
        expect_val("t4_done_hi", SEL_DONE, 8'h01);
        expect_val("t4_pdone_ready", SEL_READY, 8'h00);
        expect_val("t4_pdone_memout", SEL_MEM, 8'h17);
        step();
        pif.prog_mode = 1'b0;
        step();
        tb_oe = 1'b0; rd_en = 1'b1;
        expect_val("t4_run_read7", SEL_BUS, 8'h17);
        expect_val("t4_done_kept", SEL_DONE, 8'h01);
        step();
        rd_en = 1'b0;

        // Test 5: partial load of 6 words, aborted handshake on exit not written
        pif.prog_mode = 1'b1;
        step();
        expect_val("t5_done_cleared", SEL_DONE, 8'h00);
        for (int i = 0; i < 6; i++) begin
            pif.prog_valid = 1'b1; pif.prog_data = 8'h60 + 8'(i);
            expect_val("t5_paddr", SEL_PADDR, 8'(i));
            step();
        end
        pif.prog_mode = 1'b0; pif.prog_data = 8'hEE;
        step();
        pif.prog_valid = 1'b0;
        expect_val("t5_ready_lo", SEL_READY, 8'h00);
        expect_val("t5_done_lo", SEL_DONE, 8'h00);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            expect_val("t5_contents", SEL_MEM, (a < 6) ? 8'h60 + 8'(a) : 8'h10 + 8'(a));
            step();
        end

        // Test 6: reset in the middle of a load
        pif.prog_mode = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            pif.prog_valid = 1'b1; pif.prog_data = 8'h90 + 8'(i);
            step();
        end
        pif.prog_data = 8'h99; rst_n = 1'b0;
        step();
        rst_n = 1'b1; pif.prog_mode = 1'b0; pif.prog_valid = 1'b0;
        check_clear("t6");

        step();
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
